// File: rtl/fm_sweep_sched_if.sv
// fm_sweep_sched_if: control, config and increment bundle between the sweep sequencer and its user.
interface fm_sweep_sched_if #(parameter int W = 20, parameter int DW = 16);
   logic start, abort, loop_en, grant;
   logic [W-1:0] cfg_start, cfg_stop, cfg_step;
   logic [DW-1:0] cfg_dwell, cfg_hold;
   logic [W-1:0] incr;
   logic update, busy, done, cfg_err;
   modport master(
      output start, abort, loop_en, grant, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_hold,
      input incr, update, busy, done, cfg_err
   );
   modport slave(
      input start, abort, loop_en, grant, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_hold,
      output incr, update, busy, done, cfg_err
   );
endinterface

// File: rtl/fm_sweep_sched.sv
// fm_sweep_sched: grant-paced triangular sweep (up, hold, down, optional loop) of the SPWM12 phase increment.
module fm_sweep_sched #(parameter int W = 20, parameter int DW = 16) (
   input logic clk,
   input logic rst_n,
   fm_sweep_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, UP, HOLD, DOWN} state_t;
   state_t state, nState;
   logic [W-1:0] incrQ, nIncr, shStart, shStop, shStep, nStart, nStop, nStep, upVal, dnVal;
   logic [DW-1:0] dwellCnt, holdCnt, shDwell, shHold, nDwell, nHoldCnt, nShDwell, nShHold;
   logic updateQ, busyQ, doneQ, errQ, nUpdate, nDone, nErr, stepEv;
   logic [W:0] sum, diff;
   // One extra bit lets the clamp see overflow past stop and borrow below zero.
   assign sum = {1'b0, incrQ} + {1'b0, shStep};
   assign diff = {1'b0, incrQ} - {1'b0, shStep};
   assign upVal = (sum > {1'b0, shStop}) ? shStop : sum[W-1:0];
   assign dnVal = (diff[W] || diff[W-1:0] < shStart) ? shStart : diff[W-1:0];
   assign stepEv = bus.grant && dwellCnt == shDwell;
   assign bus.incr = incrQ;
   assign bus.update = updateQ;
   assign bus.busy = busyQ;
   assign bus.done = doneQ;
   assign bus.cfg_err = errQ;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         incrQ <= '0;
         updateQ <= 1'b0;
         busyQ <= 1'b0;
         doneQ <= 1'b0;
         errQ <= 1'b0;
         dwellCnt <= '0;
         holdCnt <= '0;
         shStart <= '0;
         shStop <= '0;
         shStep <= '0;
         shDwell <= '0;
         shHold <= '0;
      end else begin
         state <= nState;
         incrQ <= nIncr;
         updateQ <= nUpdate;
         busyQ <= nState != IDLE;
         doneQ <= nDone;
         errQ <= nErr;
         dwellCnt <= nDwell;
         holdCnt <= nHoldCnt;
         shStart <= nStart;
         shStop <= nStop;
         shStep <= nStep;
         shDwell <= nShDwell;
         shHold <= nShHold;
      end
   end
   always_comb begin
      nState = state;
      nIncr = incrQ;
      nUpdate = 1'b0;
      nDone = 1'b0;
      nErr = 1'b0;
      nDwell = dwellCnt;
      nHoldCnt = holdCnt;
      nStart = shStart;
      nStop = shStop;
      nStep = shStep;
      nShDwell = shDwell;
      nShHold = shHold;
      if (bus.abort) begin
         nState = IDLE;
         nDwell = '0;
         nHoldCnt = '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               if (bus.cfg_step == '0 || bus.cfg_stop < bus.cfg_start) nErr = 1'b1;
               else begin
                  nStart = bus.cfg_start;
                  nStop = bus.cfg_stop;
                  nStep = bus.cfg_step;
                  nShDwell = bus.cfg_dwell;
                  nShHold = bus.cfg_hold;
                  nIncr = bus.cfg_start;
                  nUpdate = 1'b1;
                  nDwell = '0;
                  nState = UP;
               end
            end
            UP: if (bus.grant) begin
               nDwell = stepEv ? '0 : dwellCnt + 1'b1;
               if (stepEv && incrQ == shStop) begin
                  nState = HOLD;
                  nHoldCnt = '0;
               end else if (stepEv) begin
                  nIncr = upVal;
                  nUpdate = 1'b1;
               end
            end
            HOLD: if (bus.grant) begin
               if (holdCnt == shHold) begin
                  nState = DOWN;
                  nDwell = '0;
               end else nHoldCnt = holdCnt + 1'b1;
            end
            DOWN: if (bus.grant) begin
               nDwell = stepEv ? '0 : dwellCnt + 1'b1;
               if (stepEv && incrQ == shStart) begin
                  nState = bus.loop_en ? UP : IDLE;
                  nDone = !bus.loop_en;
               end else if (stepEv) begin
                  nIncr = dnVal;
                  nUpdate = 1'b1;
               end
            end
            default: nState = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fm_sweep_sched.sv
// tb_fm_sweep_sched: randomized sweeps checked grant by grant against a precomputed per-grant outcome list.
module tb_fm_sweep_sched;
   localparam int W = 20;
   localparam int DW = 16;
   localparam int MAXV = (1 << W) - 1;
   typedef struct {int upd; int incr; int done; int busy; int loopEn;} ev_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   ev_t q[$];
   fm_sweep_sched_if #(.W(W), .DW(DW)) bus();
   fm_sweep_sched #(.W(W), .DW(DW)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic void pushEv(int upd, int v, int done, int busy, int loopEn);
      ev_t e;
      e.upd = upd;
      e.incr = v;
      e.done = done;
      e.busy = busy;
      e.loopEn = loopEn;
      q.push_back(e);
   endfunction

   // Expected outcome of every grant of a sweep; loopEn 2 means the bench may drive anything.
   function automatic void buildSweep(int s, int e, int st, int d, int h, int passes);
      int v = s;
      q.delete();
      for (int p = 0; p < passes; p++) begin
         while (v != e) begin
            for (int i = 0; i < d; i++) pushEv(0, v, 0, 1, 2);
            v = (v + st > e) ? e : v + st;
            pushEv(1, v, 0, 1, 2);
         end
         for (int i = 0; i <= d; i++) pushEv(0, v, 0, 1, 2);
         for (int i = 0; i <= h; i++) pushEv(0, v, 0, 1, 2);
         while (v != s) begin
            for (int i = 0; i < d; i++) pushEv(0, v, 0, 1, 2);
            v = (v - st < s) ? s : v - st;
            pushEv(1, v, 0, 1, 2);
         end
         for (int i = 0; i < d; i++) pushEv(0, v, 0, 1, 2);
         pushEv(0, v, p == passes - 1, p != passes - 1, p != passes - 1);
      end
   endfunction

   task automatic setCfg(input int s, input int e, input int st, input int d, input int h);
      bus.cfg_start = W'(s);
      bus.cfg_stop = W'(e);
      bus.cfg_step = W'(st);
      bus.cfg_dwell = DW'(d);
      bus.cfg_hold = DW'(h);
   endtask

   task automatic pulseGrants(input int n);
      for (int i = 0; i < n; i++) begin
         bus.grant = 1'b1;
         @(negedge clk);
         bus.grant = 1'b0;
      end
   endtask

   task automatic runSweep(input int s, input int e, input int st, input int d, input int h, input int passes, input int maxGap);
      buildSweep(s, e, st, d, h, passes);
      @(negedge clk);
      setCfg(s, e, st, d, h);
      bus.start = 1'b1;
      bus.grant = 1'($urandom % 2);
      @(negedge clk);
      bus.start = 1'b0;
      bus.grant = 1'b0;
      check("start_incr", bus.incr, s);
      check("start_upd", bus.update, 1);
      check("start_busy", bus.busy, 1);
      foreach (q[i]) begin
         repeat ($urandom_range(0, maxGap)) begin
            setCfg($urandom % 4096, $urandom % 4096, $urandom % 64, $urandom % 4, $urandom % 4);
            bus.start = 1'($urandom % 4 == 0);
            bus.loop_en = 1'($urandom % 2);
            @(negedge clk);
            bus.start = 1'b0;
            check("gap_upd", bus.update, 0);
            check("gap_err", bus.cfg_err, 0);
            check("gap_busy", bus.busy, 1);
         end
         bus.grant = 1'b1;
         bus.loop_en = (q[i].loopEn == 2) ? 1'($urandom % 2) : 1'(q[i].loopEn);
         @(negedge clk);
         bus.grant = 1'b0;
         check("grant_upd", bus.update, q[i].upd);
         check("grant_incr", bus.incr, q[i].incr);
         check("grant_done", bus.done, q[i].done);
         check("grant_busy", bus.busy, q[i].busy);
      end
      @(negedge clk);
      check("end_done", bus.done, 0);
      check("end_busy", bus.busy, 0);
      check("end_incr", bus.incr, s);
   endtask

   initial begin
      int s, e, st;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.loop_en = 1'b0;
      bus.grant = 1'b0;
      setCfg(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("rst_incr", bus.incr, 0);
      check("rst_upd", bus.update, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.cfg_err, 0);
      rst_n = 1'b1;
      pulseGrants(3);
      check("idle_grant_upd", bus.update, 0);
      check("idle_grant_incr", bus.incr, 0);
      runSweep(1000, 1300, 100, 0, 1, 1, 0);
      runSweep(0, 250, 100, 0, 0, 1, 2);
      runSweep(1000, 1300, 100, 3, 1, 1, 6);
      runSweep(1000, 1300, 100, 0, 1, 3, 3);
      runSweep(500, 500, 7, 1, 0, 1, 2);
      runSweep(MAXV - 255, MAXV, 'hC0000, 0, 0, 1, 1);
      runSweep(0, MAXV, MAXV, 1, 2, 2, 1);
      for (int n = 0; n < 20; n++) begin
         s = $urandom_range(0, MAXV);
         e = s + $urandom_range(0, 1500);
         if (e > MAXV) e = MAXV;
         st = $urandom_range((e - s) / 10 + 1, 700);
         runSweep(s, e, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 2), 4);
      end
      @(negedge clk);
      setCfg(1000, 1300, 100, 0, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      pulseGrants(2);
      check("pre_abort_incr", bus.incr, 1200);
      bus.abort = 1'b1;
      bus.grant = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      bus.grant = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_incr", bus.incr, 1200);
      check("abort_done", bus.done, 0);
      check("abort_upd", bus.update, 0);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("start_abort_busy", bus.busy, 0);
      check("start_abort_upd", bus.update, 0);
      check("start_abort_incr", bus.incr, 1200);
      setCfg(1000, 1300, 0, 0, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("step0_err", bus.cfg_err, 1);
      check("step0_busy", bus.busy, 0);
      check("step0_upd", bus.update, 0);
      @(negedge clk);
      check("step0_err_pulse", bus.cfg_err, 0);
      setCfg(600, 500, 10, 0, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("order_err", bus.cfg_err, 1);
      check("order_busy", bus.busy, 0);
      check("order_incr", bus.incr, 1200);
      setCfg(1000, 1300, 100, 0, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      pulseGrants(7);
      check("pre_rst_incr", bus.incr, 1200);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_incr", bus.incr, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_upd", bus.update, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulseGrants(2);
      check("post_rst_idle", bus.busy, 0);
      runSweep(1000, 1300, 100, 0, 1, 1, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fm_sweep_sched.md
# fm_sweep_sched

Sequencer that drives the 20-bit phase increment of the SPWM12 sigma-PWM carrier generator. It produces a programmable triangular frequency sweep: ramp up, hold, ramp down, with an optional loop. Each step is paced by the PWM grant strobe. It replaces a fixed-step increment source and sits between the register/config logic and the SPWM12 `increment` input, running entirely in the 480 MHz PWM clock domain.

## Interface

Parameters:
- `W`, 20, increment width (matches SPWM12 `increment`)
- `DW`, 16, dwell/hold counter width

Ports:
- `clk`  in  1  PWM clock; single clock domain
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  one-cycle request; accepted only in IDLE
- `abort`  in  1  one-cycle request; returns to IDLE from any state
- `loop_en`  in  1  sampled at end of DOWN; 1 = restart UP
- `cfg_start`  in  W  sweep low bound
- `cfg_stop`  in  W  sweep high bound
- `cfg_step`  in  W  increment delta per step event
- `cfg_dwell`  in  DW  grants per step minus 1
- `cfg_hold`  in  DW  grants in HOLD minus 1
- `grant`  in  1  one-cycle strobe from SPWM12 `PWM_grant`
- `incr`  out  W  increment to SPWM12
- `update`  out  1  high exactly in the cycle `incr` takes a new value
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse on normal sweep completion
- `cfg_err`  out  1  one-cycle pulse when a start is rejected

## Operation

- States: IDLE, UP, HOLD, DOWN. All outputs are registered.
- Reset values: state=IDLE, `incr`=0, `update`=0, `busy`=0, `done`=0, `cfg_err`=0, counters=0.
- IDLE: `grant` is ignored and `incr` retains its last value, so the carrier keeps running.
- Start acceptance, when `start` is high in IDLE:
  - Rejected if `cfg_step`==0 or `cfg_stop`<`cfg_start`: `cfg_err` pulses, state stays IDLE.
  - Otherwise: all cfg_* are latched into shadow registers, `incr`<=`cfg_start`, `update`<=1, dwell counter<=0, state<=UP.
  - Later cfg_* changes have no effect until the next accepted start.
  - `start` outside IDLE is ignored (no error).
- Step event: a `grant` arrives while the dwell counter == latched `dwell`.
  - The counter then clears; otherwise each grant increments it.
- UP, on each step event:
  - If `incr`==stop: go to HOLD, hold counter<=0, no update.
  - Else `incr`<=min(`incr`+step, stop), `update`<=1.
  - The sum is computed in W+1 bits, so it never wraps.
- HOLD: each `grant` increments the hold counter. The grant that finds counter==latched `hold` moves the state to DOWN and clears the dwell counter. `incr` is unchanged.
- DOWN, on each step event:
  - If `incr`==start: if `loop_en` then go to UP (dwell counter<=0, no update); else go to IDLE with a `done` pulse.
  - Else `incr`<=max(`incr`-step, start), `update`<=1.
  - The difference is computed with borrow detection, so it never underflows.
- Abort:
  - Next state is IDLE from any state and counters clear.
  - `incr` holds its value; no `done`, no `update`.
  - Abort wins over a simultaneous `start` or `grant`.
  - Abort in IDLE is a no-op.
- A `grant` in the same cycle as an accepted `start` is ignored.
- Reset asserted mid-sweep forces all reset values immediately.

## Timing

- Latency from `start` accepted at cycle n: `incr`=cfg_start, `update`=1 and `busy`=1 at n+1.
- Latency from `grant` at cycle n that causes a step: new `incr` and `update`=1 at n+1. `update` is never high two consecutive cycles unless grants are consecutive.
- A normal completion at cycle n gives `done`=1 and `busy`=0 at n+1.
- `cfg_err` at n+1 after a rejected start at n.
- With `grant` every cycle, one step per (dwell+1) cycles is sustained, with no bubbles.

## Test plan

- Basic sweep: start=1000, stop=1300, step=100, dwell=0, hold=1, loop_en=0, then 10 grants.
  - `incr` sequence: 1000, 1100, 1200, 1300.
  - Grant 4 enters HOLD; grant 6 enters DOWN.
  - Then 1200, 1100, 1000.
  - Grant 10 gives `done` and IDLE, with `incr`=1000 retained.
  - 7 `update` pulses in total.
- Clamping: start=0, stop=250, step=100, dwell=0 → UP gives 0, 100, 200, 250; DOWN gives 150, 50, 0. No wrap.
- Dwell pacing: dwell=3 → `incr` changes only on every 4th grant. Grants spaced 1 to 7 cycles apart do not alter the count.
- Loop: loop_en=1 with the basic config → after reaching 1000 in DOWN it re-enters UP without a `done`, and the next step gives 1100. Dropping `loop_en` ends the sweep after the following DOWN.
- Abort/start conflicts:
  - `abort` in UP with `incr`=1200 → IDLE next cycle, `incr` stays 1200, no `done`.
  - Simultaneous `start` and `abort` in IDLE → stays IDLE.
  - `start` while busy → ignored.
- Errors and reset:
  - step=0, or stop=500 with start=600 → `cfg_err` pulse, `busy` stays 0.
  - `rst_n` low mid-DOWN → `incr`=0 and state IDLE immediately.
